// File: rtl/memctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// FSM encoding, internal RAM window and default timeout.
package memctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXT_WAIT = 2'd1,
        EXT_DONE = 2'd2,
        EXT_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] INT_RAM_BASE  = 32'h0000_2B10;
    localparam logic [31:0] INT_RAM_LIMIT = 32'h0000_2F0F;

    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for external accesses; expired is raised
// on the LIMIT-th enabled cycle after a clear.
module mem_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ext_mem_access_ctrl.sv
// Internal/external data-memory access controller with CPU stall.
// Define MEMCTRL_TIMEOUT_EN to enable the ext_ack timeout (bus_err).
module ext_mem_access_ctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] int_rdata,
    output logic              int_we,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              bus_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state;
    state_t            w_next;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_acc;
    logic              w_start;
    logic              w_ack_ok;
    logic              w_to;
    logic              w_expired;

    assign w_acc = mem_rd | mem_wr;

`ifdef MEMCTRL_TIMEOUT_EN
    mem_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start),
        .i_en     (r_state == EXT_WAIT),
        .o_expired(w_expired)
    );
    assign bus_err = (r_state == EXT_ERR);
`else
    assign w_expired = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= mem_wr;
                r_req   <= 1'b1;
            end
            // A write (including rd+wr) never updates the load buffer.
            if (w_ack_ok) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_rdata <= ext_rdata;
                end
            end
            if (w_to) begin
                r_req <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_ack_ok  = 1'b0;
        w_to      = 1'b0;
        int_we    = 1'b0;
        stall     = 1'b0;
        cpu_rdata = cs ? r_rdata : int_rdata;
        unique case (r_state)
            IDLE: begin
                int_we = mem_wr & ~cs;
                if (w_acc && cs) begin
                    stall   = 1'b1;
                    w_start = 1'b1;
                    w_next  = EXT_WAIT;
                end
            end
            EXT_WAIT: begin
                stall = 1'b1;
                if (ext_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = EXT_DONE;
                end else if (w_expired) begin
                    w_to   = 1'b1;
                    w_next = EXT_ERR;
                end
            end
            EXT_DONE: begin
                w_next = IDLE;
            end
            EXT_ERR: begin
                cpu_rdata = '0;
                w_next    = IDLE;
            end
        endcase
    end

    assign ext_req   = r_req;
    assign ext_we    = r_we;
    assign ext_addr  = r_addr;
    assign ext_wdata = r_wdata;

endmodule

// File: tb/tb_ext_mem_access_ctrl.sv
// Directed + randomized bench for ext_mem_access_ctrl against a
// transaction-level model of internal/external accesses.
module tb_ext_mem_access_ctrl;
    import memctrl_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] int_rdata;
    logic          int_we;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic          bus_err;

    int checks   = 0;
    int failures = 0;

    // Model state: last data returned by an external read.
    logic [DW-1:0] exp_cap;

    always #5 clk = ~clk;

    ext_mem_access_ctrl #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .cs       (cs),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .wdata    (wdata),
        .int_rdata(int_rdata),
        .int_we   (int_we),
        .ext_req  (ext_req),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata),
        .ext_ack  (ext_ack),
        .cpu_rdata(cpu_rdata),
        .stall    (stall),
        .bus_err  (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic int_access(input logic [31:0] a, input logic rd,
                              input logic wr, input logic [31:0] wd,
                              input logic [31:0] rdat);
        @(negedge clk);
        cs = 1'b0; addr = a; mem_rd = rd; mem_wr = wr;
        wdata = wd; int_rdata = rdat; ext_ack = 1'b0;
        #2;
        chk("int_stall", 32'(stall), 32'd0);
        chk("int_we", 32'(int_we), 32'(wr));
        chk("int_rdata", cpu_rdata, rdat);
        chk("int_no_req", 32'(ext_req), 32'd0);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        #2;
        chk("int_we_off", 32'(int_we), 32'd0);
        chk("int_no_req2", 32'(ext_req), 32'd0);
    endtask

    // Ack arrives on wait cycle k (k >= 1).
    task automatic ext_access(input logic [31:0] a, input logic rd,
                              input logic wr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int k);
        @(negedge clk);
        cs = 1'b1; addr = a; mem_rd = rd; mem_wr = wr;
        wdata = wd; ext_ack = 1'b0;
        #2;
        chk("xreq_stall", 32'(stall), 32'd1);
        chk("xreq_int_we", 32'(int_we), 32'd0);
        chk("xreq_req_low", 32'(ext_req), 32'd0);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            addr      = $urandom;
            wdata     = $urandom;
            ext_ack   = (i == k);
            ext_rdata = (i == k) ? rdat : $urandom;
            #2;
            chk("xwait_stall", 32'(stall), 32'd1);
            chk("xwait_req", 32'(ext_req), 32'd1);
            chk("xwait_addr", ext_addr, a);
            chk("xwait_we", 32'(ext_we), 32'(wr));
            chk("xwait_wdata", ext_wdata, wd);
            chk("xwait_buserr", 32'(bus_err), 32'd0);
        end
        if (rd && !wr) exp_cap = rdat;
        @(negedge clk);
        ext_ack   = 1'($urandom_range(0, 1));
        ext_rdata = $urandom;
        #2;
        chk("xdone_stall", 32'(stall), 32'd0);
        chk("xdone_req", 32'(ext_req), 32'd0);
        chk("xdone_rdata", cpu_rdata, exp_cap);
        chk("xdone_buserr", 32'(bus_err), 32'd0);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0; ext_ack = 1'b0;
        #2;
        chk("xidle_stall", 32'(stall), 32'd0);
        chk("xidle_req", 32'(ext_req), 32'd0);
        chk("xidle_rdata", cpu_rdata, exp_cap);
    endtask

    initial begin
        rst = 1'b1; addr = '0; cs = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
        wdata = '0; int_rdata = '0; ext_rdata = '0; ext_ack = 1'b0;
        exp_cap = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_req", 32'(ext_req), 32'd0);
        chk("rst_we", 32'(ext_we), 32'd0);
        chk("rst_addr", ext_addr, 32'd0);
        chk("rst_wdata", ext_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;

        int_access(INT_RAM_BASE, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
        int_access(INT_RAM_LIMIT, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'h0);
        int_access(INT_RAM_LIMIT, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);

        ext_access(32'h0000_3000, 1'b1, 1'b0, 32'h0, 32'hCAFE_BABE, 4);
        ext_access(32'h0000_2F10, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1);
        ext_access(32'h0000_4000, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h5555, 2);

        // Spurious ack while idle must not capture or start anything.
        @(negedge clk);
        cs = 1'b1; ext_ack = 1'b1; ext_rdata = 32'hFFFF_0000;
        #2;
        chk("spur_stall", 32'(stall), 32'd0);
        @(negedge clk);
        ext_ack = 1'b0;
        #2;
        chk("spur_req", 32'(ext_req), 32'd0);
        chk("spur_rdata", cpu_rdata, exp_cap);

        // Reset in the middle of a wait aborts the transaction.
        @(negedge clk);
        cs = 1'b1; addr = 32'h0000_5000; mem_rd = 1'b1;
        @(negedge clk);
        #2;
        chk("abort_req_pre", 32'(ext_req), 32'd1);
        rst = 1'b1; mem_rd = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_cap = '0;
        chk("abort_req", 32'(ext_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_rdata", cpu_rdata, 32'd0);
        int_access(INT_RAM_BASE, 1'b1, 1'b0, 32'h0, 32'h7777_8888);

`ifdef MEMCTRL_TIMEOUT_EN
        @(negedge clk);
        cs = 1'b1; addr = 32'h0000_6000; mem_rd = 1'b1; ext_ack = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            #2;
            chk("to_wait_req", 32'(ext_req), 32'd1);
            chk("to_wait_err", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        #2;
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_err_req", 32'(ext_req), 32'd0);
        chk("to_err_stall", 32'(stall), 32'd0);
        chk("to_err_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        mem_rd = 1'b0;
        #2;
        chk("to_after_err", 32'(bus_err), 32'd0);
        chk("to_after_stall", 32'(stall), 32'd0);
        ext_access(32'h0000_6004, 1'b1, 1'b0, 32'h0, 32'h600D_600D, TO);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] r;
            logic        rd;
            logic        wr;
            int          kind;
            a    = $urandom;
            d    = $urandom;
            r    = $urandom;
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            if ($urandom_range(0, 1) == 0) begin
                int_access(a, rd, wr, d, r);
            end else begin
                ext_access(a, rd, wr, d, r, $urandom_range(1, 6));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_mem_access_ctrl.md
Name: ext_mem_access_ctrl

Overview:
Data-memory access controller placed directly downstream of the address decoder's chip-select output (cs: 0 = internal 1 kB RAM at 0x2B10–0x2F0F, 1 = external memory).
- Internal accesses: completed in the same cycle, no stall.
- External accesses: run a registered req/ack handshake, with the CPU stalled until data returns.
- Read data from both sources is muxed back to the CPU.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, max cycles waiting for ext_ack; used only with MEMCTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  CPU data address.
- cs  in  1  from address decoder; 0 = internal, 1 = external.
- mem_rd  in  1  CPU load request.
- mem_wr  in  1  CPU store request.
- wdata  in  DATA_W  CPU store data.
- int_rdata  in  DATA_W  internal RAM read data (combinational).
- int_we  out  1  internal RAM write enable.
- ext_req  out  1  external request, registered.
- ext_we  out  1  external write qualifier, registered.
- ext_addr  out  ADDR_W  registered external address.
- ext_wdata  out  DATA_W  registered external write data.
- ext_rdata  in  DATA_W  external read data, valid with ext_ack.
- ext_ack  in  1  external completion, single-cycle pulse.
- cpu_rdata  out  DATA_W  load data to CPU.
- stall  out  1  freezes CPU pipeline while high.
- bus_err  out  1  timeout pulse; tied 0 without MEMCTRL_TIMEOUT_EN.

Behaviour:
- FSM states: IDLE, EXT_WAIT, EXT_DONE (plus EXT_ERR with the macro).
- Reset values: state=IDLE; ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, captured rdata=0, bus_err=0. Reset mid-transaction aborts it: ext_req is low after the reset edge.
- Access valid: acc = mem_rd | mem_wr. If both are set, it is treated as a write (mem_wr wins) and no read data is captured.
- Internal path, cs=0:
  - int_we = mem_wr & ~cs & (state==IDLE), combinational.
  - cpu_rdata = int_rdata.
  - stall = 0.
  - Zero extra latency; the FSM stays in IDLE.
- External start: in IDLE with acc & cs:
  - stall = 1 combinationally in that same cycle.
  - At the edge: ext_addr<=addr, ext_wdata<=wdata, ext_we<=mem_wr, ext_req<=1, state<=EXT_WAIT.
- EXT_WAIT:
  - stall = 1 and ext_req is held high; ext_addr, ext_we and ext_wdata remain stable.
  - On ext_ack: capture ext_rdata (reads only), ext_req<=0, state<=EXT_DONE.
  - Minimum external latency: request cycle + 1 wait cycle + done cycle = 3 cycles if ack arrives on the first EXT_WAIT cycle.
- EXT_DONE: stall=0, cpu_rdata = captured data, state<=IDLE next edge. The CPU advances on this edge, so no retrigger occurs.
- In IDLE and EXT_DONE, cpu_rdata selects by cs: internal data when cs=0, captured data when cs=1.
- Boundary conditions:
  - ext_ack outside EXT_WAIT is ignored.
  - Changes on addr, cs or wdata during stall are ignored (values already latched).
  - Address 0x2F0F or 0x2B10 with cs=0 is internal; 0x2F10 with cs=1 is external. The decision comes from cs only.
  - No access (acc=0): int_we=0, ext_req stays 0, stall=0.
- External writes also stall until ack (strictly ordered, no posted writes).

Optional Feature:
MEMCTRL_TIMEOUT_EN
- Defined:
  - Counter clears on entering EXT_WAIT and increments each EXT_WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without ack: ext_req<=0, state<=EXT_ERR.
  - EXT_ERR lasts one cycle: stall=0, bus_err=1, cpu_rdata=0; then IDLE.
  - Ack on the same cycle as the count hitting the limit: ack wins.
- Undefined: no counter, bus_err tied 0, EXT_WAIT waits indefinitely.

Decomposition:
- Package memctrl_pkg:
  - State enum encoding (IDLE=0, EXT_WAIT=1, EXT_DONE=2, EXT_ERR=3).
  - Internal RAM base/limit constants (0x2B10/0x2F0F), shared with the decoder.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: mem_timeout_cnt (clear/enable/expired), instantiated only under the macro.

Test Plan:
- Internal read: addr=0x2B10, cs=0, mem_rd=1, int_rdata=0x12345678 → cpu_rdata=0x12345678 same cycle; stall=0; ext_req never asserted.
- Internal write: addr=0x2F0F, cs=0, mem_wr=1, wdata=0xA5A5A5A5 → int_we=1 for one cycle; no stall.
- External read: addr=0x3000, cs=1, mem_rd=1; ack with ext_rdata=0xCAFEBABE after 4 cycles:
  - stall high from the request cycle through the ack cycle.
  - ext_addr=0x3000 stable throughout.
  - EXT_DONE cycle: cpu_rdata=0xCAFEBABE, stall=0.
- External write with ack on the first EXT_WAIT cycle → ext_we=1, ext_wdata=wdata, total stall 2 cycles; spurious ack in IDLE → no state change.
- rst asserted in EXT_WAIT → next cycle ext_req=0, stall=0, state=IDLE; a following internal read works normally.
- With MEMCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, external read, no ack:
  - ext_req drops after 8 EXT_WAIT cycles.
  - bus_err=1 for one cycle with cpu_rdata=0, then IDLE.
  - Repeat with ack on cycle 8 → normal completion, bus_err=0.
